// File: rtl/acc_inval_queue.sv
// acc_inval_queue
//   Buffers cache-line invalidation requests from the vector accelerator and
//   presents them, line-aligned and in arrival order, to the D-cache
//   invalidation port.
//
// Parameters
//   DEPTH      : number of queue entries (power of two, >= 2)
//   ADDR_W     : invalidation address width
//   LINE_BYTES : D-cache line size in bytes
//
// Ports
//   clk_i, rst_ni  : clock (rising edge), asynchronous active-low reset
//   acc_cons_en_i  : coherence enable; when low, inputs are discarded and
//                    the queue is cleared
//   flush_i        : synchronous clear, wins over push and pop
//   in_valid_i / in_addr_i / in_ready_o    : request side
//   out_valid_o / out_addr_o / out_ready_i : cache side
//   count_o        : number of occupied entries
//
// Build option
//   ACC_INVAL_QUEUE_COALESCE_EN : when defined, a push whose aligned address
//   matches an occupied entry (other than a head popping this cycle) is
//   accepted and dropped.
module acc_inval_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       acc_cons_en_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [ADDR_W-1:0]          in_addr_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [ADDR_W-1:0]          out_addr_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q,  count_d;

  logic [ADDR_W-1:0] in_aligned;
  logic              push_hs;
  logic              pop;
  logic              store;
  logic              dup;

  assign in_aligned  = in_addr_i & MASK;
  assign out_valid_o = (count_q != '0);
  assign out_addr_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;
  assign in_ready_o  = acc_cons_en_i ? (count_q != FULL) : 1'b1;
  assign push_hs     = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

`ifdef ACC_INVAL_QUEUE_COALESCE_EN
  // Entry i is occupied when its distance from the read pointer is below
  // count; the head is not a match candidate when it leaves this cycle.
  always_comb begin
    logic [PW-1:0] offs;
    dup  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ((CW'(offs) < count_q) && !((offs == '0) && pop) &&
          (mem_q[i] == in_aligned))
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign store = push_hs && acc_cons_en_i && !flush_i && !dup;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!acc_cons_en_i || flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(store);
      count_d  = count_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the output is gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= in_aligned;
  end

endmodule

// File: tb/tb_acc_inval_queue.sv
module tb_acc_inval_queue;
  localparam int DEPTH = 4;
  localparam int LB    = 16;
  localparam logic [63:0] AMASK = ~64'(LB - 1);

  logic        clk_i = 1'b0;
  logic        rst_ni, acc_cons_en_i, flush_i, in_valid_i, out_ready_i;
  logic [63:0] in_addr_i;
  logic        in_ready_o, out_valid_o;
  logic [63:0] out_addr_o;
  logic [2:0]  count_o;

  acc_inval_queue #(.DEPTH(DEPTH), .ADDR_W(64), .LINE_BYTES(LB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc_cons_en_i(acc_cons_en_i),
    .flush_i(flush_i), .in_valid_i(in_valid_i), .in_addr_i(in_addr_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_addr_o(out_addr_o), .out_ready_i(out_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of line addresses plus a log of pops.
  logic [63:0] q[$];
  logic [63:0] outs[$];

  always @(negedge rst_ni) q.delete();

  always @(posedge clk_i) begin
    if (!rst_ni) q.delete();
    else if (!acc_cons_en_i || flush_i) q.delete();
    else begin
      automatic bit          popv  = (q.size() != 0) && out_ready_i;
      automatic bit          pushv = in_valid_i && (q.size() != DEPTH);
      automatic logic [63:0] a     = in_addr_i & AMASK;
      automatic bit          dupv  = 1'b0;
`ifdef ACC_INVAL_QUEUE_COALESCE_EN
      foreach (q[i]) if (q[i] == a && !(i == 0 && popv)) dupv = 1'b1;
`endif
      if (popv) outs.push_back(q.pop_front());
      if (pushv && !dupv) q.push_back(a);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    automatic logic exp_rdy = acc_cons_en_i ? (q.size() != DEPTH) : 1'b1;
    chk("count", 64'(count_o), 64'(q.size()));
    chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    if (q.size() != 0) chk("out_addr", out_addr_o, q[0]);
    else chk("out_addr_idle", out_addr_o, 64'h0);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [63:0] a);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    repeat (DEPTH + 1) step();
    out_ready_i = 1'b0;
  endtask

  initial begin
    int base;
    int npop;
    rst_ni = 1'b0; acc_cons_en_i = 1'b0; flush_i = 1'b0;
    in_valid_i = 1'b0; in_addr_i = '0; out_ready_i = 1'b0;
    repeat (2) step();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_addr", out_addr_o, 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    rst_ni = 1'b1;
    acc_cons_en_i = 1'b1;
    step();

    // Alignment and one-cycle latency
    in_valid_i = 1'b1; in_addr_i = 64'h8000_0013;
    #1 chk("no_comb_path", 64'(out_valid_o), 64'd0);
    step(); in_valid_i = 1'b0;
    chk("align_valid", 64'(out_valid_o), 64'd1);
    chk("align_addr", out_addr_o, 64'h8000_0010);
    chk("align_count", 64'(count_o), 64'd1);
    drain();

    // Full queue refuses a push even with a same-cycle pop
    base = outs.size();
    push(64'h100); push(64'h200); push(64'h300); push(64'h400);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b1; in_addr_i = 64'h500; out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("full_pop_count", 64'(count_o), 64'd3);
    chk("full_next_head", out_addr_o, 64'h200);
    drain();
    chk("full_log0", outs[base], 64'h100);
    chk("full_log3", outs[base+3], 64'h400);
    chk("full_log_len", 64'(outs.size() - base), 64'd4);

    // Steady push/pop across the pointer wrap
    push(64'h1000); push(64'h1010);
    base = outs.size();
    for (int k = 0; k < 3*DEPTH; k++) begin
      in_valid_i = 1'b1; in_addr_i = 64'h1020 + 64'(k) * 64'h10;
      out_ready_i = 1'b1;
      step();
      chk("steady_count", 64'(count_o), 64'd2);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    for (int k = 0; k < 3*DEPTH; k++)
      chk("steady_order", outs[base+k], 64'h1000 + 64'(k) * 64'h10);
    drain();

    // Flush wins over a same-cycle push
    push(64'hA00); push(64'hA10); push(64'hA20);
    flush_i = 1'b1; in_valid_i = 1'b1; in_addr_i = 64'hBEE0;
    #1 chk("flush_ready", 64'(in_ready_o), 64'd1);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    repeat (3) step();
    chk("flush_stays_empty", 64'(out_valid_o), 64'd0);

    // Duplicate line addresses
    push(64'h240); push(64'h24F);
`ifdef ACC_INVAL_QUEUE_COALESCE_EN
    chk("dup_count", 64'(count_o), 64'd1);
`else
    chk("dup_count", 64'(count_o), 64'd2);
`endif
    npop = 0;
    out_ready_i = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (out_valid_o) begin
        chk("dup_addr", out_addr_o, 64'h240);
        npop++;
      end
      step();
    end
    out_ready_i = 1'b0;
`ifdef ACC_INVAL_QUEUE_COALESCE_EN
    chk("dup_pops", 64'(npop), 64'd1);
`else
    chk("dup_pops", 64'(npop), 64'd2);
`endif

    // Coherence disabled: accept, discard, clear
    push(64'hC00); push(64'hC10);
    acc_cons_en_i = 1'b0; in_valid_i = 1'b1; in_addr_i = 64'hC20;
    #1 chk("dis_ready", 64'(in_ready_o), 64'd1);
    step(); step();
    chk("dis_count", 64'(count_o), 64'd0);
    in_valid_i = 1'b0; acc_cons_en_i = 1'b1;
    step();

    // Asynchronous reset mid-drain
    push(64'hD00); push(64'hD10); push(64'hD20);
    out_ready_i = 1'b1;
    step();
    chk("pre_rst_count", 64'(count_o), 64'd2);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_count", 64'(count_o), 64'd0);
    out_ready_i = 1'b0;
    step();
    rst_ni = 1'b1;
    push(64'h707);
    chk("post_rst_count", 64'(count_o), 64'd1);
    chk("post_rst_addr", out_addr_o, 64'h700);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/acc_inval_queue.md
ACC_INVAL_QUEUE -- requirements
Module: acc_inval_queue

Buffers cache-line invalidation requests from the vector accelerator (acc_resp.inval_valid/inval_addr) and presents them to the CVA6 D-cache invalidation port (inval_ready).

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the invalidation address width.
REQ-003 SHALL have parameter LINE_BYTES, default 16, meaning the D-cache line size in bytes (DcacheLineWidth/8).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port acc_cons_en_i, input, 1 bit, accelerator coherence enable.
REQ-007 SHALL have port flush_i, input, 1 bit, synchronous queue clear.
REQ-008 SHALL have port in_valid_i, input, 1 bit, accelerator invalidation request valid.
REQ-009 SHALL have port in_addr_i, input, ADDR_W bits, invalidation byte address.
REQ-010 SHALL have port in_ready_o, output, 1 bit, request accepted.
REQ-011 SHALL have port out_valid_o, output, 1 bit, invalidation presented to the cache.
REQ-012 SHALL have port out_addr_o, output, ADDR_W bits, line-aligned invalidation address.
REQ-013 SHALL have port out_ready_i, input, 1 bit, cache accepted the invalidation.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1) bits, number of occupied entries.

Function
REQ-015 SHALL treat a push as in_valid_i && in_ready_o, and a pop as out_valid_o && out_ready_i.
REQ-016 SHALL store each pushed address with its low $clog2(LINE_BYTES) bits forced to zero.
REQ-017 SHALL drive in_ready_o = (count_o != DEPTH) while acc_cons_en_i=1, with no full-queue bypass (push into a full queue is refused even when a pop occurs that cycle).
REQ-018 SHALL, while acc_cons_en_i=0, drive in_ready_o=1, discard every input, and clear the queue at the next edge.
REQ-019 SHALL be strictly FIFO; out_addr_o is the oldest entry, and out_valid_o = (count_o != 0).
REQ-020 SHALL make a pushed entry visible on out_valid_o no earlier than the cycle after the push (1-cycle latency; no combinational in-to-out path).
REQ-021 SHALL hold out_addr_o stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL, on simultaneous push and pop, leave count_o unchanged and accept the new entry behind the remaining ones.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH without a bubble.
REQ-024 SHALL give flush_i priority over push and pop: count_o becomes 0 at the next edge, and a same-cycle push is dropped while in_ready_o still reads 1.
REQ-025 SHALL keep out_valid_o low and in_ready_o at its rule value from REQ-017/018 for all cycles after a flush until a new push.

Reset
REQ-026 SHALL, on rst_ni=0 (asynchronous, at any time, including mid-transfer), clear the pointers and count, giving count_o=0, out_valid_o=0 and out_addr_o=0.
REQ-027 SHALL drive in_ready_o to its REQ-017/018 value during reset (1, since the queue is empty).
REQ-028 SHALL resume operation on the first clock edge after rst_ni rises, with no wait cycles.

Configuration
REQ-029 SHALL, when ACC_INVAL_QUEUE_COALESCE_EN is defined, accept and discard a push whose aligned address equals any occupied entry, excluding the head if it pops in the same cycle; count_o does not change for that push.
REQ-030 SHALL, when ACC_INVAL_QUEUE_COALESCE_EN is undefined, store every push, including duplicates, and contain no comparator logic.

Verification
REQ-031 SHALL cover: reset; cons_en=1; push 0x8000_0013 with out_ready=0 -> next cycle out_valid=1, out_addr=0x8000_0010, count=1.
REQ-032 SHALL cover: push 0x100, 0x200, 0x300, 0x400 with out_ready=0 -> count=4, in_ready=0; then assert in_valid and out_ready together -> the push is refused, 0x100 pops, and count=3.
REQ-033 SHALL cover: steady push and pop every cycle for 3*DEPTH cycles -> addresses come out in order across the pointer wrap and count stays constant.
REQ-034 SHALL cover: 3 entries queued, flush_i and in_valid both asserted -> next cycle count=0, out_valid=0, and the pushed address never appears at the output.
REQ-035 SHALL cover: with COALESCE_EN, push 0x240 then 0x24F -> count=1 and one output 0x240; without COALESCE_EN -> count=2 and output 0x240 twice.
REQ-036 SHALL cover: rst_ni low mid-drain with 2 entries queued -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
